// File: rtl/mux_nx1_valid.sv
// N:1 valid/ready multiplexer with direct-select or round-robin arbitration and a registered,
// back-pressurable output stage. Define MUX_NX1_XFER_CNT_EN to add the xfer_count port.
module mux_nx1_valid #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
`ifdef MUX_NX1_XFER_CNT_EN
  ,
  output logic [7:0]                xfer_count
`endif
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic             cand_found;
  logic [SEL_W-1:0] cand_idx;
  logic [SEL_W-1:0] scan_idx;
  logic             grant;

  assign load_en = !out_valid_q || out_ready;

  // Round-robin scan wraps naturally because CHANNELS is a power of two.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    scan_idx   = '0;
    if (!mode) begin
      cand_found = in_valid[select];
      cand_idx   = select;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        scan_idx = rr_ptr_q + SEL_W'(i);
        if (!cand_found && in_valid[scan_idx]) begin
          cand_found = 1'b1;
          cand_idx   = scan_idx;
        end
      end
    end
  end

  // Reset gates in_ready so no producer sees an accept while state is being cleared.
  assign grant = reset && load_en && cand_found;

  always_comb begin
    in_ready = '0;
    if (grant) begin
      in_ready[cand_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = cand_found;
      if (cand_found) begin
        out_data_d = in_data[cand_idx*WIDTH +: WIDTH];
        out_sel_d  = cand_idx;
        if (mode) begin
          rr_ptr_d = cand_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

`ifdef MUX_NX1_XFER_CNT_EN
  logic [7:0] xfer_q, xfer_d;

  always_comb begin
    xfer_d = xfer_q;
    if (out_valid_q && out_ready) begin
      xfer_d = xfer_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_q <= '0;
    end else begin
      xfer_q <= xfer_d;
    end
  end

  assign xfer_count = xfer_q;
`endif

endmodule

// File: tb/tb_mux_nx1_valid.sv
// Scoreboard bench for mux_nx1_valid (4 channels x 4 bits): expected output words are queued
// when stimulus is applied and compared once the edge has produced them.
module tb_mux_nx1_valid;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [1:0]  select;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_sel;
  logic        out_ready;
`ifdef MUX_NX1_XFER_CNT_EN
  logic [7:0]  xfer_count;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       v;
    logic [3:0] d;
    logic [1:0] s;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Reference model state (value after the next edge once predict has run).
  logic       m_ov;
  logic [3:0] m_od;
  logic [1:0] m_os;
  logic [1:0] m_rr;
  logic [7:0] m_cnt;
  logic [3:0] exp_rdy;

  always #5 clk = ~clk;

  mux_nx1_valid #(
    .WIDTH(4),
    .CHANNELS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .select(select),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_sel(out_sel),
    .out_ready(out_ready)
`ifdef MUX_NX1_XFER_CNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  task automatic model_reset();
    m_ov  = 1'b0;
    m_od  = '0;
    m_os  = '0;
    m_rr  = '0;
    m_cnt = '0;
    sb.delete();
  endtask

  task automatic set_in(input logic md, input logic [1:0] sel, input logic [3:0] vld,
                        input logic [15:0] dat, input logic rdy);
    mode      = md;
    select    = sel;
    in_valid  = vld;
    in_data   = dat;
    out_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Computes the expected in_ready for the current inputs and queues the expected output word.
  task automatic predict();
    int k;
    logic [1:0] idx;
    k = -1;
    if (!mode) begin
      if (in_valid[select]) k = int'(select);
    end else begin
      for (int i = 0; i < 4; i++) begin
        idx = m_rr + 2'(i);
        if (k < 0 && in_valid[idx]) k = int'(idx);
      end
    end
    exp_rdy = '0;
    if (m_ov && out_ready) m_cnt = m_cnt + 8'd1;
    if (!m_ov || out_ready) begin
      if (k >= 0) begin
        exp_rdy[k] = 1'b1;
        m_ov = 1'b1;
        m_od = in_data[k*4 +: 4];
        m_os = 2'(k);
        if (mode) m_rr = 2'(k + 1);
      end else begin
        m_ov = 1'b0;
      end
    end
    e.v = m_ov;
    e.d = m_od;
    e.s = m_os;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_in(1'b0, 2'd0, 4'b0000, 16'h0000, 1'b0);
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    set_in(1'b0, 2'd0, 4'b0001, 16'h0005, 1'b0);
    predict();
    tick();
    e = sb.pop_front();
    total++;
    if ({out_valid, out_data, out_sel} !== e) begin
      bad++;
      $display("FAIL reset_preload got v=%0b d=%h s=%0d want v=%0b d=%h s=%0d",
               out_valid, out_data, out_sel, e.v, e.d, e.s);
    end
    // Assert reset mid-cycle while a word is held and stalled.
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({out_valid, out_data, out_sel, in_ready} !== 11'd0) begin
      bad++;
      $display("FAIL reset_async got v=%0b d=%h s=%0d rdy=%b want all zero",
               out_valid, out_data, out_sel, in_ready);
    end
    model_reset();
    #2;
    reset = 1'b1;
    tick();
    set_in(1'b0, 2'd2, 4'b0100, 16'h0A00, 1'b1);
    predict();
    total++;
    if (in_ready !== 4'b0100) begin
      bad++;
      $display("FAIL reset_first_ready got %b want 0100", in_ready);
    end
    tick();
    e = sb.pop_front();
    total++;
    if ({out_valid, out_data, out_sel} !== {1'b1, 4'hA, 2'd2}) begin
      bad++;
      $display("FAIL reset_first_word got v=%0b d=%h s=%0d want v=1 d=a s=2",
               out_valid, out_data, out_sel);
    end
    total++;
    if ({out_valid, out_data, out_sel} !== e) begin
      bad++;
      $display("FAIL reset_first_sb got v=%0b d=%h s=%0d want v=%0b d=%h s=%0d",
               out_valid, out_data, out_sel, e.v, e.d, e.s);
    end
  endtask

  task automatic test_mode0_unselected();
    set_in(1'b0, 2'd1, 4'b1101, 16'hBC0D, 1'b1);
    predict();
    total++;
    if (in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL m0_unsel_ready got %b want 0000", in_ready);
    end
    tick();
    e = sb.pop_front();
    total++;
    if (out_valid !== 1'b0 || {out_valid, out_data, out_sel} !== e) begin
      bad++;
      $display("FAIL m0_unsel_out got v=%0b d=%h s=%0d want v=0 d=%h s=%0d",
               out_valid, out_data, out_sel, e.d, e.s);
    end
  endtask

  task automatic test_rr_fairness();
    logic [1:0] want [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 2'd0, 4'b1111, 16'($urandom), 1'b1);
      predict();
      total++;
      if (in_ready !== (4'b0001 << want[i])) begin
        bad++;
        $display("FAIL rr_fair_ready[%0d] got %b want %b", i, in_ready, 4'b0001 << want[i]);
      end
      tick();
      e = sb.pop_front();
      total++;
      if (out_sel !== want[i] || {out_valid, out_data, out_sel} !== e) begin
        bad++;
        $display("FAIL rr_fair_out[%0d] got v=%0b d=%h s=%0d want v=1 d=%h s=%0d",
                 i, out_valid, out_data, out_sel, e.d, want[i]);
      end
    end
  endtask

  task automatic test_rr_wrap();
    logic [1:0] want [3] = '{2'd2, 2'd0, 2'd1};
    logic [3:0] vld  [3] = '{4'b0100, 4'b0011, 4'b0011};
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 2'd0, vld[i], 16'h9876, 1'b1);
      predict();
      tick();
      e = sb.pop_front();
      total++;
      if (out_sel !== want[i] || out_valid !== 1'b1 || {out_valid, out_data, out_sel} !== e) begin
        bad++;
        $display("FAIL rr_wrap[%0d] got v=%0b d=%h s=%0d want v=1 d=%h s=%0d",
                 i, out_valid, out_data, out_sel, e.d, want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    set_in(1'b0, 2'd3, 4'b1000, 16'h7000, 1'b1);
    predict();
    tick();
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 2'd3, 4'b1111, 16'h1234, 1'b0);
      predict();
      total++;
      if (in_ready !== 4'b0000) begin
        bad++;
        $display("FAIL bp_ready[%0d] got %b want 0000", i, in_ready);
      end
      tick();
      e = sb.pop_front();
      total++;
      if ({out_valid, out_data, out_sel} !== {1'b1, 4'h7, 2'd3} ||
          {out_valid, out_data, out_sel} !== e) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%0b d=%h s=%0d want v=1 d=7 s=3",
                 i, out_valid, out_data, out_sel);
      end
    end
    set_in(1'b0, 2'd1, 4'b1111, 16'h1234, 1'b1);
    predict();
    total++;
    if (in_ready !== 4'b0010) begin
      bad++;
      $display("FAIL bp_release_ready got %b want 0010", in_ready);
    end
    tick();
    e = sb.pop_front();
    total++;
    if ({out_valid, out_data, out_sel} !== {1'b1, 4'h3, 2'd1}) begin
      bad++;
      $display("FAIL bp_release_out got v=%0b d=%h s=%0d want v=1 d=3 s=1",
               out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      set_in(1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom),
             ($urandom_range(0, 3) != 0));
      predict();
      total++;
      if (in_ready !== exp_rdy) begin
        bad++;
        $display("FAIL rand_ready[%0d] got %b want %b", i, in_ready, exp_rdy);
      end
      tick();
      e = sb.pop_front();
      total++;
      if ({out_valid, out_data, out_sel} !== e) begin
        bad++;
        $display("FAIL rand_out[%0d] got v=%0b d=%h s=%0d want v=%0b d=%h s=%0d",
                 i, out_valid, out_data, out_sel, e.v, e.d, e.s);
      end
    end
`ifdef MUX_NX1_XFER_CNT_EN
    total++;
    if (xfer_count !== m_cnt) begin
      bad++;
      $display("FAIL rand_count got %0d want %0d", xfer_count, m_cnt);
    end
`endif
  endtask

`ifdef MUX_NX1_XFER_CNT_EN
  task automatic test_counter();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    total++;
    if (xfer_count !== 8'd0) begin
      bad++;
      $display("FAIL cnt_reset got %0d want 0", xfer_count);
    end
    // 258 edges with ready: the first only loads, the rest are 257 transfers.
    for (int i = 0; i < 258; i++) begin
      set_in(1'b0, 2'd0, 4'b0001, 16'($urandom), 1'b1);
      predict();
      tick();
      e = sb.pop_front();
    end
    total++;
    if (xfer_count !== 8'd1 || xfer_count !== m_cnt) begin
      bad++;
      $display("FAIL cnt_wrap got %0d want 1", xfer_count);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 2'd0, 4'b0001, 16'h0000, 1'b0);
      predict();
      tick();
      e = sb.pop_front();
    end
    total++;
    if (xfer_count !== 8'd1) begin
      bad++;
      $display("FAIL cnt_stall got %0d want 1", xfer_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mode0_unselected();
    test_rr_fairness();
    test_rr_wrap();
    test_backpressure();
    test_random();
`ifdef MUX_NX1_XFER_CNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_nx1_valid.md
# mux_nx1_valid

Parametrised N:1 multiplexer with per-channel valid/ready handshakes and a registered, back-pressurable output stage. It succeeds the fixed 4:1 4-bit valid mux. It adds configurable data width and channel count, and a round-robin arbitration mode alongside direct select. It sits between several producer channels and a single consumer.

## Interface
Parameters:
- `WIDTH`, 4: data bits per channel.
- `CHANNELS`, 4: number of input channels; power of two, 2..16.
- `SEL_W`, `$clog2(CHANNELS)`: derived; must not be overridden.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `mode` input 1: 0 = direct select, 1 = round-robin.
- `select` input SEL_W: channel index used in mode 0.
- `in_data` input CHANNELS*WIDTH: flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid` input CHANNELS: per-channel valid.
- `in_ready` output CHANNELS: per-channel accept strobe; combinational; at most one bit set.
- `out_data` output WIDTH: registered output data.
- `out_valid` output 1: registered output valid.
- `out_sel` output SEL_W: registered index of the channel whose data is held.
- `out_ready` input 1: consumer accept.

## Operation
- `load_en = !out_valid | out_ready`: the output register can take new data this cycle.
- Candidate in mode 0:
  - Channel `select`, if `in_valid[select]`.
  - Otherwise none.
  - Valids on other channels are ignored and left pending.
- Candidate in mode 1:
  - First channel with `in_valid` set, scanning upward from `rr_ptr` and wrapping CHANNELS-1 -> 0.
- Grant:
  - When `load_en` and a candidate k exists: `in_ready[k]=1`.
  - At the edge: `out_data <= in_data[k]`, `out_sel <= k`, `out_valid <= 1`.
  - In mode 1 only: `rr_ptr <= (k+1) mod CHANNELS`.
- `load_en` with no candidate: `out_valid <= 0`; `out_data` and `out_sel` hold their last values.
- `!load_en` (`out_valid & !out_ready`): all `in_ready` are 0; the output registers are frozen.
- Mode 0 never modifies `rr_ptr`.
- A `mode` or `select` change applies to the next load decision; no state is flushed.
- A consumer transfer is `out_valid & out_ready` at a rising edge. A new grant can occur in the same cycle, giving full throughput.
- Reset values:
  - `out_data=0`, `out_valid=0`, `out_sel=0`, `rr_ptr=0`, `in_ready=0`.
  - Counter (if enabled) = 0.
- Reset asserted mid-transfer discards the held word immediately, without waiting for a clock edge.

## Timing
- Latency of 1 cycle: data granted at edge n is visible on `out_*` after edge n.
- `in_ready` depends combinationally on `in_valid`, `select`, `mode`, `out_valid`, `out_ready` and `rr_ptr`. There is no combinational path from `in_data` to any output.
- Throughput is one word per cycle while `out_ready` is high and a candidate exists.
- Producers must hold `in_data`/`in_valid` stable until they see `in_ready`.
- Reset release is synchronous-safe: the first grant can occur at the first rising edge after `reset` goes high.

## Configuration
- `MUX_NX1_XFER_CNT_EN` defined:
  - Adds output port `xfer_count` [7:0].
  - It increments on every consumer transfer and wraps 255 -> 0.
  - It resets to 0.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

## Test plan
- **Reset:** assert `reset=0` mid-operation with `out_valid=1` -> all outputs read 0 within the same cycle. Release, then `mode=0`, `select=2`, `in_valid=4'b0100`, `in_data` ch2=4'hA, `out_ready=1` -> `in_ready=4'b0100`; next cycle `out_data=4'hA`, `out_sel=2`, `out_valid=1`.
- **Mode 0, unselected valid:** `select=1`, `in_valid=4'b1101` -> `in_ready=0`; `out_valid` goes 0 after the edge.
- **Round-robin fairness:** `mode=1`, all four valid continuously, `out_ready=1` -> `out_sel` sequence 0,1,2,3,0 on consecutive cycles.
- **Round-robin wrap:** `mode=1`, `rr_ptr=3`, `in_valid=4'b0011` -> grant ch0, then ch1.
- **Backpressure:** `out_valid=1`, `out_ready=0` for 3 cycles with `in_valid=4'b1111` -> `in_ready=0`, `out_data`/`out_sel` stable. Raise `out_ready` -> next grant occurs in that same cycle.
- **Counter (`MUX_NX1_XFER_CNT_EN`):** 257 consecutive transfers -> `xfer_count=1`. Stalled cycles do not increment.
